// File: rtl/rom_loader.sv
// Boot-time program loader: assembles a big-endian byte stream (16-bit word count, then
// words) into ROM writes at addresses 0..N-1 and holds the CPU in reset until it completes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset, waiting for start_i; CPU held in reset
// S_LEN_HI | waiting for word-count high byte
// S_LEN_LO | waiting for word-count low byte; range-checks the count
// S_DATA_HI| waiting for data word high byte
// S_DATA_LO| waiting for data word low byte
// S_WRITE  | one-cycle ROM write strobe
// S_DONE   | load complete, CPU released
// S_ERR    | load failed or aborted, CPU held in reset
module rom_loader #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [WORD_W-1:0] rom_data_o,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [16:0] CAP   = 17'(1) << ADDR_W;

    state_t             r_state;
    logic [15:0]        r_len;
    logic [7:0]         r_word_hi;
    logic [CNT_W-1:0]   r_count;
    logic               r_byte_ready;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_data;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    state_t             w_state_nxt;
    logic               w_xfer;
    logic               w_busy_st;
    logic               w_idle_st;
    logic [15:0]        w_len_full;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_last;

    assign w_xfer      = byte_valid_i & r_byte_ready;
    assign w_idle_st   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_busy_st   = !w_idle_st;
    assign w_len_full  = {r_len[15:8], byte_i};
    assign w_count_inc = r_count + 1'b1;
    // count is one bit wider than the address so a full-capacity load terminates without wrapping
    assign w_last      = (32'(w_count_inc) == 32'(r_len));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0)              w_state_nxt = S_DONE;
                    else if ({1'b0, w_len_full} > CAP)    w_state_nxt = S_ERR;
                    else                                  w_state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (w_xfer) w_state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_xfer) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_state_nxt = w_last ? S_DONE : S_DATA_HI;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // abort overrides any same-cycle transfer, including the one that would start a write
        if (abort_i && w_busy_st) w_state_nxt = S_ERR;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_word_hi    <= '0;
            r_count      <= '0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ready <= (w_state_nxt == S_LEN_HI) || (w_state_nxt == S_LEN_LO) ||
                            (w_state_nxt == S_DATA_HI) || (w_state_nxt == S_DATA_LO);
            r_we         <= (w_state_nxt == S_WRITE);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                            (w_state_nxt != S_ERR);
            r_done       <= (w_state_nxt == S_DONE);
            r_err        <= (w_state_nxt == S_ERR);
            r_cpu_reset  <= (w_state_nxt != S_DONE);

            if (w_idle_st && start_i) r_count <= '0;

            if (w_xfer && !abort_i) begin
                case (r_state)
                    S_LEN_HI:  r_len[15:8] <= byte_i;
                    S_LEN_LO:  r_len[7:0]  <= byte_i;
                    S_DATA_HI: r_word_hi   <= byte_i;
                    default: ;
                endcase
            end

            if (w_state_nxt == S_WRITE) begin
                r_addr <= r_count[ADDR_W-1:0];
                r_data <= WORD_W'({r_word_hi, byte_i});
            end

            if (r_state == S_WRITE) r_count <= w_count_inc;
        end
    end

    assign byte_ready_o = r_byte_ready;
    assign rom_we_o     = r_we;
    assign rom_addr_o   = r_addr;
    assign rom_data_o   = r_data;
    assign cpu_reset_o  = r_cpu_reset;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule
